sense_ctrl: RTL and testbench

SENSE_CTRL -- requirements
Module: sense_ctrl

---
 rtl/sense_pkg.sv | 38 +++
 rtl/sync_2ff.sv | 27 ++
 rtl/sense_ctrl.sv | 174 +++++++++++++++++
 tb/tb_sense_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sense_pkg.sv
// Shared types and default timing for the LED/comparator sense controller.
package sense_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_REPORT = 3'd4,
    ST_GAP    = 3'd5
  } state_e;

  localparam int DEF_SETTLE_CYC = 16;
  localparam int DEF_SAMPLE_WIN = 8;
  localparam int DEF_THRESH     = 5;

  // Longest gap: period_sel = 7 gives 2^11 cycles.
  localparam int GAP_MAX = 2048;

  localparam logic [7:0] EVT_MAX = 8'd255;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for bringing asynchronous analog-side signals into clk.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Metastability stage followed by the stable output stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= {WIDTH{1'b0}};
      sync_q <= {WIDTH{1'b0}};
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/sense_ctrl.sv
// Sense controller: clears the analog latch, lights the LED, counts comparator
// hits over a fixed window and reports a held detect plus a saturating event count.
module sense_ctrl
  import sense_pkg::*;
#(
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int SAMPLE_WIN = DEF_SAMPLE_WIN,
  parameter int THRESH     = DEF_THRESH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmp_in,
  input  logic       start,
  input  logic       cont_mode,
  input  logic [2:0] period_sel,
  input  logic       clr_cnt,
  output logic       latch_rst,
  output logic       led_en,
  output logic       busy,
  output logic       sample_valid,
  output logic       detect,
  output logic [7:0] evt_cnt
);

  localparam int HITS_W = $clog2(SAMPLE_WIN + 1);
  localparam int CNT_W  = $clog2(max3(SETTLE_CYC, SAMPLE_WIN, GAP_MAX));

  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_WIN - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [HITS_W-1:0]   hits_q, hits_d;
  logic                latch_rst_q, latch_rst_d;
  logic                led_en_q, led_en_d;
  logic                busy_q, busy_d;
  logic                sample_valid_q, sample_valid_d;
  logic                detect_q, detect_d;
  logic [7:0]          evt_cnt_q, evt_cnt_d;
  logic                cmp_sync;
  logic [CNT_W-1:0]    gap_last;
  logic                report_d;
  logic                hit_ok;

  sync_2ff #(
    .WIDTH (1)
  ) u_cmp_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cmp_in),
    .q     (cmp_sync)
  );

  // Loading the counter on GAP entry is what captures period_sel; at the
  // largest setting the shift wraps to zero and the subtraction yields all ones.
  assign gap_last = (CNT_ONE << ({1'b0, period_sel} + 4'd4)) - CNT_ONE;

  // Sequencer: next state, phase counter and hit accumulation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hits_d  = hits_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CLR;
          hits_d  = {HITS_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLR: begin
        state_d = ST_SETTLE;
        cnt_d   = SETTLE_LAST;
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = ST_SAMPLE;
          cnt_d   = SAMPLE_LAST;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      ST_SAMPLE: begin
        hits_d = hits_q + HITS_W'(cmp_sync);
        if (cnt_q == CNT_ZERO) begin
          state_d = ST_REPORT;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      ST_REPORT: begin
        if (cont_mode) begin
          state_d = ST_GAP;
          cnt_d   = gap_last;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (cont_mode) begin
          state_d = ST_CLR;
          hits_d  = {HITS_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
        hits_d  = {HITS_W{1'b0}};
      end
    endcase
  end

  // Output flops are fed from the next state so they line up with state_q.
  always_comb begin
    report_d       = (state_d == ST_REPORT);
    hit_ok         = (32'(hits_d) >= 32'($unsigned(THRESH)));
    latch_rst_d    = (state_d == ST_CLR);
    led_en_d       = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
    busy_d         = (state_d != ST_IDLE);
    sample_valid_d = report_d;
    if (report_d) begin
      detect_d = hit_ok;
    end else begin
      detect_d = detect_q;
    end
    if (clr_cnt) begin
      evt_cnt_d = 8'd0;
    end else if (report_d && hit_ok && (evt_cnt_q != EVT_MAX)) begin
      evt_cnt_d = evt_cnt_q + 8'd1;
    end else begin
      evt_cnt_d = evt_cnt_q;
    end
  end

  // State, counters and outputs, all with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= CNT_ZERO;
      hits_q         <= {HITS_W{1'b0}};
      latch_rst_q    <= 1'b0;
      led_en_q       <= 1'b0;
      busy_q         <= 1'b0;
      sample_valid_q <= 1'b0;
      detect_q       <= 1'b0;
      evt_cnt_q      <= 8'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      hits_q         <= hits_d;
      latch_rst_q    <= latch_rst_d;
      led_en_q       <= led_en_d;
      busy_q         <= busy_d;
      sample_valid_q <= sample_valid_d;
      detect_q       <= detect_d;
      evt_cnt_q      <= evt_cnt_d;
    end
  end

  assign latch_rst    = latch_rst_q;
  assign led_en       = led_en_q;
  assign busy         = busy_q;
  assign sample_valid = sample_valid_q;
  assign detect       = detect_q;
  assign evt_cnt      = evt_cnt_q;

endmodule

// File: tb/tb_sense_ctrl.sv
// Self-checking bench for sense_ctrl: table of single-shot measurements, hand
// sequences for reset/ignore/saturation, and a randomized run against a model.
module tb_sense_ctrl;

  localparam int SETTLE   = 16;
  localparam int WIN      = 8;
  localparam int THRESH_C = 5;
  // Edge of the start sample is edge 0; the result strobe follows CLR+SETTLE+SAMPLE.
  localparam int MEAS_LAT = 1 + SETTLE + WIN;
  // Continuous repeat at period_sel=0: measurement, one REPORT cycle, 16-cycle gap.
  localparam int SAT_PER  = MEAS_LAT + 1 + 16;
  localparam int NRAND    = 24;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmp_in;
  logic       start;
  logic       cont_mode;
  logic [2:0] period_sel;
  logic       clr_cnt;
  logic       latch_rst;
  logic       led_en;
  logic       busy;
  logic       sample_valid;
  logic       detect;
  logic [7:0] evt_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [7:0] mask;
    logic       clr;
    logic       det;
    logic [7:0] evt;
  } vec_t;

  vec_t vecs [0:13];

  sense_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmp_in       (cmp_in),
    .start        (start),
    .cont_mode    (cont_mode),
    .period_sel   (period_sel),
    .clr_cnt      (clr_cnt),
    .latch_rst    (latch_rst),
    .led_en       (led_en),
    .busy         (busy),
    .sample_valid (sample_valid),
    .detect       (detect),
    .evt_cnt      (evt_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One single-shot measurement from IDLE; cmp_in follows mask bit i during the
  // i-th SAMPLE cycle (allowing for the two synchronizer flops).
  task automatic run_meas(input vec_t v, input logic pdet, input logic [7:0] pevt, input string tag);
    logic [12:0] exp_v;
    logic [12:0] act_v;
    int idx;
    start  = 1'b1;
    cmp_in = 1'b0;
    for (int e = 0; e <= MEAS_LAT + 1; e++) begin
      clr_cnt = v.clr && (e == MEAS_LAT);
      tick;
      start = 1'b0;
      exp_v = {(e == 0), (e >= 1 && e <= MEAS_LAT - 1), (e <= MEAS_LAT), (e == MEAS_LAT),
               (e >= MEAS_LAT) ? v.det : pdet, (e >= MEAS_LAT) ? v.evt : pevt};
      act_v = {latch_rst, led_en, busy, sample_valid, detect, evt_cnt};
      chk($sformatf("%s_e%0d", tag, e), act_v, exp_v);
      idx = e + 1 - SETTLE;
      cmp_in = (idx >= 0 && idx < WIN) ? v.mask[idx] : 1'b0;
    end
    clr_cnt = 1'b0;
  endtask

  int          n_sv, first_e, last_e, exp_e, n_busy;
  int          c, nmeas;
  logic        done, clr_now, m_det, m_hit;
  logic [7:0]  m_evt, mask;
  logic [2:0]  ps;
  logic [12:0] exp_r, act_r;
  int          ridx;
  vec_t        vtmp;

  initial begin
    vecs[0]  = '{8'hFF, 1'b0, 1'b1, 8'd1};
    vecs[1]  = '{8'h0F, 1'b0, 1'b0, 8'd1};
    vecs[2]  = '{8'h1F, 1'b0, 1'b1, 8'd2};
    vecs[3]  = '{8'h00, 1'b0, 1'b0, 8'd2};
    vecs[4]  = '{8'hAA, 1'b0, 1'b0, 8'd2};
    vecs[5]  = '{8'hAB, 1'b0, 1'b1, 8'd3};
    vecs[6]  = '{8'hF0, 1'b0, 1'b0, 8'd3};
    vecs[7]  = '{8'hFE, 1'b0, 1'b1, 8'd4};
    vecs[8]  = '{8'hFF, 1'b0, 1'b1, 8'd5};
    vecs[9]  = '{8'hFF, 1'b0, 1'b1, 8'd6};
    vecs[10] = '{8'hF8, 1'b0, 1'b1, 8'd7};
    vecs[11] = '{8'hFF, 1'b1, 1'b1, 8'd0};
    vecs[12] = '{8'hE0, 1'b0, 1'b0, 8'd0};
    vecs[13] = '{8'hFF, 1'b0, 1'b1, 8'd1};

    rst_n = 1'b0; cmp_in = 1'b1; start = 1'b0; cont_mode = 1'b0;
    period_sel = 3'd0; clr_cnt = 1'b0;
    repeat (3) tick;
    chk("rst_latch_rst", latch_rst, 1'b0);
    chk("rst_led_en", led_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sample_valid", sample_valid, 1'b0);
    chk("rst_detect", detect, 1'b0);
    chk("rst_evt_cnt", evt_cnt, 8'd0);
    rst_n = 1'b1; cmp_in = 1'b0;
    repeat (2) tick;
    chk("idle_busy", busy, 1'b0);

    for (int i = 0; i < 14; i++) begin
      run_meas(vecs[i], (i == 0) ? 1'b0 : vecs[i-1].det, (i == 0) ? 8'd0 : vecs[i-1].evt,
               $sformatf("vec%0d", i));
    end

    // Reset in the third SAMPLE cycle aborts the measurement.
    start = 1'b1; cmp_in = 1'b1;
    for (int e = 0; e < 20; e++) begin
      tick;
      start = 1'b0;
    end
    rst_n = 1'b0;
    tick;
    chk("midrst_latch_rst", latch_rst, 1'b0);
    chk("midrst_led_en", led_en, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_sample_valid", sample_valid, 1'b0);
    chk("midrst_detect", detect, 1'b0);
    chk("midrst_evt_cnt", evt_cnt, 8'd0);
    rst_n = 1'b1;
    n_sv = 0; n_busy = 0;
    for (int e = 0; e < 40; e++) begin
      tick;
      if (sample_valid) n_sv++;
      if (busy) n_busy++;
    end
    chk("midrst_no_strobe", n_sv, 0);
    chk("midrst_idle", n_busy, 0);
    vtmp = '{8'hFF, 1'b0, 1'b1, 8'd1};
    run_meas(vtmp, 1'b0, 8'd0, "after_rst");

    // Starts in SETTLE and GAP are ignored; dropping cont_mode in GAP ends the run.
    n_sv = 0; first_e = -1; cmp_in = 1'b1; period_sel = 3'd0;
    for (int e = 0; e <= 70; e++) begin
      start     = (e == 0 || e == 5 || e == 6 || e == 30);
      cont_mode = (e < 35);
      tick;
      if (sample_valid) begin
        n_sv++;
        if (first_e < 0) first_e = e;
      end
      if (e == MEAS_LAT + 16) chk("gap_last_busy", busy, 1'b1);
      if (e == MEAS_LAT + 17) chk("gap_end_idle", busy, 1'b0);
    end
    start = 1'b0;
    chk("ignore_strobes", n_sv, 1);
    chk("ignore_first_strobe", first_e, MEAS_LAT);
    chk("ignore_evt", evt_cnt, 8'd2);

    // Continuous mode at period_sel=0 until the counter saturates.
    clr_cnt = 1'b1; tick; clr_cnt = 1'b0;
    chk("clr_idle", evt_cnt, 8'd0);
    cont_mode = 1'b1; period_sel = 3'd0; cmp_in = 1'b1; start = 1'b1;
    n_sv = 0; last_e = 0;
    for (int e = 0; e < 300 * SAT_PER + 100 && n_sv < 300; e++) begin
      tick;
      start = 1'b0;
      if (sample_valid) begin
        n_sv++;
        exp_e = (n_sv == 1) ? MEAS_LAT : last_e + SAT_PER;
        chk($sformatf("sat_time%0d", n_sv), e, exp_e);
        chk($sformatf("sat_evt%0d", n_sv), evt_cnt, (n_sv > 255) ? 255 : n_sv);
        last_e = e;
        if (n_sv == 300) cont_mode = 1'b0;
      end
    end
    cont_mode = 1'b0;
    chk("sat_strobe_count", n_sv, 300);
    tick;
    chk("sat_idle", busy, 1'b0);
    chk("sat_final_evt", evt_cnt, 8'd255);

    // Randomized continuous run with random clears, starts and period changes.
    clr_cnt = 1'b1; tick; clr_cnt = 1'b0;
    m_evt = 8'd0; m_det = 1'b1;
    c = 0; nmeas = 0; done = 1'b0;
    mask = 8'($urandom); m_hit = ($countones(mask) >= THRESH_C);
    cont_mode = 1'b1; start = 1'b1; cmp_in = 1'b0; period_sel = 3'($urandom);
    for (int e = 0; e < 20000; e++) begin
      clr_now = ($urandom_range(0, 11) == 0);
      clr_cnt = clr_now;
      tick;
      start = done ? 1'b0 : 1'($urandom);
      if (clr_now) m_evt = 8'd0;
      else if (e == c + MEAS_LAT && m_hit && m_evt != 8'd255) m_evt = m_evt + 8'd1;
      if (e == c + MEAS_LAT) m_det = m_hit;
      exp_r = {(e == c), (e > c && e < c + MEAS_LAT), !(done && e > c + MEAS_LAT),
               (e == c + MEAS_LAT), m_det, m_evt};
      act_r = {latch_rst, led_en, busy, sample_valid, detect, evt_cnt};
      chk($sformatf("rand_m%0d_e%0d", nmeas, e), act_r, exp_r);
      if (done && e >= c + MEAS_LAT + 2) break;
      if (e == c + MEAS_LAT) begin
        nmeas++;
        if (nmeas == NRAND) begin
          done = 1'b1;
          cont_mode = 1'b0;
        end else begin
          ps = 3'($urandom_range(0, 3));
          period_sel = ps;
          c = c + MEAS_LAT + 1 + (1 << (ps + 4));
          mask = 8'($urandom);
          m_hit = ($countones(mask) >= THRESH_C);
        end
      end else begin
        period_sel = 3'($urandom);
      end
      ridx = e + 1 - (c + SETTLE);
      cmp_in = (ridx >= 0 && ridx < WIN) ? mask[ridx] : 1'($urandom);
    end
    clr_cnt = 1'b0;
    chk("rand_completed", done, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
